// File: rtl/mul_seq_shiftadd.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Define MUL_SIGNED_EN for two's complement operands and product.
`timescale 1ns/1ps

module mul_seq_shiftadd #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 8,
  parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] p,
  output logic               busy
);

  localparam int A_WIDTH = P_WIDTH + 1;
  localparam int C_WIDTH = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic [X_WIDTH-1:0] xr;
  logic [Y_WIDTH-1:0] yr;
  logic [A_WIDTH-1:0] acc;
  logic [A_WIDTH-1:0] acc_nx;
  logic [C_WIDTH-1:0] cnt;
  logic [P_WIDTH-1:0] p_q;
  logic [X_WIDTH:0]   hi;
  logic [X_WIDTH:0]   addend;
  logic [X_WIDTH:0]   sum;
  logic               fill;
  logic               last;
  logic               accept;
  logic               deliver;
  logic               in_idle;
  logic               in_run;
  logic               in_done;

  assign in_idle = (state == S_IDLE);
  assign in_run  = (state == S_RUN);
  assign in_done = (state == S_DONE);

  assign in_ready  = in_idle | (in_done & out_ready);
  assign out_valid = in_done;
  assign busy      = in_run;
  assign p         = p_q;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  assign last = (cnt == C_WIDTH'(Y_WIDTH - 1));
  assign hi   = acc[A_WIDTH-1:Y_WIDTH];

`ifdef MUL_SIGNED_EN
  // The final multiplier bit carries negative weight.
  assign addend = {xr[X_WIDTH-1], xr};
  assign sum    = !yr[0] ? hi :
                  last   ? hi - addend :
                           hi + addend;
  assign fill   = sum[X_WIDTH];
`else
  assign addend = {1'b0, xr};
  assign sum    = yr[0] ? hi + addend : hi;
  assign fill   = 1'b0;
`endif

  assign acc_nx = A_WIDTH'({fill, sum, acc[Y_WIDTH-1:0]} >> 1);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      in_idle: begin
        if (accept) state_nx = S_RUN;
      end
      in_run: begin
        if (last) state_nx = S_DONE;
      end
      in_done: begin
        if (deliver) state_nx = accept ? S_RUN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      xr    <= '0;
      yr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        xr  <= x;
        yr  <= y;
        acc <= '0;
        cnt <= '0;
      end else if (in_run) begin
        acc <= acc_nx;
        yr  <= yr >> 1;
        cnt <= cnt + C_WIDTH'(1);
        if (last) p_q <= acc_nx[P_WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/mul_seq_shiftadd.md
# mul_seq_shiftadd

Parametrised sequential shift-add multiplier, the iterative successor to the fixed 3x3 combinational array multiplier. It computes an X_WIDTH by Y_WIDTH product one multiplier bit per clock, so arbitrary operand widths fit in a small area. Operands enter and products leave through valid/ready handshakes. Optional signed (two's complement) operation is compiled in by macro.

## Interface
Parameters:
- X_WIDTH, default 8: multiplicand width (>= 2).
- Y_WIDTH, default 8: multiplier width (>= 2); also the iteration count.
- P_WIDTH, default X_WIDTH+Y_WIDTH: product width. Derived only; must not be overridden.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x/y operands valid.
- in_ready  output  1  block can accept operands.
- x  input  X_WIDTH  multiplicand.
- y  input  Y_WIDTH  multiplier.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  P_WIDTH  product, registered.
- busy  output  1  high in RUN state.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at a rising edge: latch x into xr and y into yr, clear the accumulator, set iteration counter cnt=0, go to RUN.
- RUN, one multiplier bit per cycle, LSB first:
  - If yr[0]=1, add xr into the upper X_WIDTH+1 bits of the accumulator. The adder is X_WIDTH+1 bits wide so the carry is kept.
  - Shift the accumulator right 1 and shift yr right 1. Increment cnt.
  - When cnt reaches Y_WIDTH-1, that cycle's step is the last one. Go to DONE.
- DONE: out_valid=1 and p = accumulator[P_WIDTH-1:0].
  - While out_ready=0, p and out_valid hold stable.
  - On out_valid&out_ready: if in_valid=1 in the same cycle, accept the new operands and go to RUN (back-to-back). Otherwise go to IDLE.
  - in_ready in DONE is combinationally equal to out_ready.
- in_ready=0 in RUN. Operands presented in RUN are ignored and are not lost: the source holds them under the handshake.
- Width rules: the product is exact and never truncated. The unsigned maximum is (2^X_WIDTH-1)(2^Y_WIDTH-1).
- x=0 or y=0 still takes the full Y_WIDTH iterations. There is no early termination.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, p=0. FSM=IDLE, cnt=0, accumulator=0.
- Latency: accept at edge E gives out_valid=1 after edge E+Y_WIDTH.
- Throughput: one product per Y_WIDTH+1 cycles with out_ready held at 1. Back-to-back acceptance in DONE removes the IDLE cycle.
- busy=1 exactly during the Y_WIDTH RUN cycles.
- p is updated only on the transition into DONE. It is constant outside that edge.
- rst_n asserted mid-RUN or mid-DONE: all outputs are forced to reset values immediately (asynchronously). The in-flight product is discarded and is never emitted.
- Release of rst_n is sampled synchronously. The first accept is possible on the first rising edge with rst_n=1.

## Configuration
- Macro MUL_SIGNED_EN.
- Defined:
  - x, y, and p are two's complement.
  - The adder operand is xr sign-extended to X_WIDTH+1 bits, and the accumulator right shift is arithmetic.
  - On the final iteration (multiplier sign bit) xr is subtracted instead of added when yr[0]=1.
  - Latency is unchanged.
- Undefined: pure unsigned operation as described in Operation.

## Test plan
- Unsigned, X=Y=8: x=255, y=255 -> out_valid after exactly 8 edges, p=0xFE01. Then x=0, y=173 -> p=0x0000.
- Unsigned, X=Y=3: exhaustive 64 pairs -> every p equals x*y, e.g. 7*7=49 (0b110001).
- Backpressure: product ready, out_ready=0 for 5 cycles -> p and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (x=3, y=5) -> new RUN starts the next cycle, and p=15 follows 8 edges later.
- Reset mid-RUN: assert rst_n=0 after 4 iterations of 200*100 -> out_valid=0, in_ready=1, p=0 immediately. After release, 12*12 -> p=144, with no stale product emitted.
- With MUL_SIGNED_EN, X=Y=8:
  - -128*-128 -> p=0x4000.
  - -1*1 -> p=0xFFFF.
  - 127*-128 -> p=0xC080.
- Random unsigned X=5, Y=11, 10k transactions with random in_valid/out_ready -> matches the reference model; no drops or duplicates.
